// File: rtl/aia_latency_sampler_pkg.sv
// Shared types and constants for the interrupt-latency sampler.
package aia_latency_pkg;

    localparam int unsigned SAMPLE_W = 32;

    // Starting value of the running minimum: any real sample replaces it.
    localparam logic [SAMPLE_W-1:0] MIN_RESET = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        STOP,
        CAPTURE
    } state_e;

endpackage

// File: rtl/aia_latency_sampler_if.sv
// Sample read port: the sampler presents the FIFO head, software pops it.
interface aia_latency_sampler_if #(
    parameter int unsigned CW = 32
) ();

    logic          rd_valid_o;
    logic          rd_ready_i;
    logic [CW-1:0] rd_data_o;

    modport master (
        output rd_valid_o,
        output rd_data_o,
        input  rd_ready_i
    );

    modport slave (
        input  rd_valid_o,
        input  rd_data_o,
        output rd_ready_i
    );

endinterface

// File: rtl/aia_edge_detect.sv
// Rising-edge detector: one register stage, edge = old 0 and current 1.
module aia_edge_detect (
    input  logic clk_i,
    input  logic rst_sys_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Remember the previous level of the input.
    always_ff @(posedge clk_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/aia_sample_fifo.sv
// Circular sample buffer with sticky overflow and synchronous flush.
module aia_sample_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_sys_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [CW-1:0]            data_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [CW-1:0]            data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [CW-1:0] hold_q;
    logic          overflow_q;
    logic          empty;
    logic          do_pop;
    logic          do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    assign valid_o    = ~empty;
    // When empty, keep showing the last sample handed out instead of a stale slot.
    assign data_o     = empty ? hold_q : mem[rd_ptr_q[AW-1:0]];
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign overflow_o = overflow_q;

    // Pointer, overflow and last-popped bookkeeping.
    always_ff @(posedge clk_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                hold_q   <= mem[rd_ptr_q[AW-1:0]];
            end
            if (push_i && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Sample storage; contents are only visible once written.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/aia_latency_sampler.sv
// Drives the cycle counter around a trigger/done window and logs each frozen count.
module aia_latency_sampler
    import aia_latency_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CW     = SAMPLE_W
) (
    input  logic                     clk_i,
    input  logic                     rst_sys_ni,
    input  logic                     enable_i,
    input  logic                     trig_i,
    input  logic                     done_i,
    input  logic                     clr_i,
    output logic                     cnt_rst_o,
    output logic                     cnt_start_o,
    output logic                     cnt_stop_o,
    input  logic [CW-1:0]            counter_i,
    aia_latency_sampler_if.master    rd,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [CW-1:0]            min_o,
    output logic [CW-1:0]            max_o,
    output logic                     busy_o
);

    localparam int unsigned SW = $clog2(SETTLE + 1);

    state_e        state_q;
    logic [SW-1:0] settle_q;
    logic          trig_rise;
    logic          done_rise;
    logic          push;
    logic          fifo_valid;
    logic [CW-1:0] fifo_data;
    logic          fifo_full;
    logic [CW-1:0] min_q;
    logic [CW-1:0] max_q;

    aia_edge_detect u_trig_edge (
        .clk_i      (clk_i),
        .rst_sys_ni (rst_sys_ni),
        .d_i        (trig_i),
        .rise_o     (trig_rise)
    );

    aia_edge_detect u_done_edge (
        .clk_i      (clk_i),
        .rst_sys_ni (rst_sys_ni),
        .d_i        (done_i),
        .rise_o     (done_rise)
    );

    // Measurement sequencer with registered counter controls.
    always_ff @(posedge clk_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            cnt_rst_o   <= 1'b0;
            cnt_start_o <= 1'b0;
            cnt_stop_o  <= 1'b0;
        end else if (!enable_i) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            cnt_rst_o   <= 1'b0;
            cnt_start_o <= 1'b0;
            cnt_stop_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig_rise) begin
                        state_q   <= CLEAR;
                        cnt_rst_o <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q     <= RUN;
                    cnt_rst_o   <= 1'b0;
                    cnt_start_o <= 1'b1;
                end
                RUN: begin
                    if (done_rise) begin
                        state_q    <= STOP;
                        cnt_stop_o <= 1'b1;
                        settle_q   <= '0;
                    end
                end
                STOP: begin
                    if (settle_q == SW'(SETTLE - 1)) begin
                        state_q     <= CAPTURE;
                        cnt_start_o <= 1'b0;
                        cnt_stop_o  <= 1'b0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_rst_o   <= 1'b0;
                    cnt_start_o <= 1'b0;
                    cnt_stop_o  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign push   = (state_q == CAPTURE) && enable_i && !clr_i;

    aia_sample_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_sys_ni (rst_sys_ni),
        .flush_i    (clr_i),
        .push_i     (push),
        .data_i     (counter_i),
        .full_o     (fifo_full),
        .pop_i      (rd.rd_ready_i),
        .valid_o    (fifo_valid),
        .data_o     (fifo_data),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    assign rd.rd_valid_o = fifo_valid;
    assign rd.rd_data_o  = fifo_data;

    // Running min/max over every captured sample, including ones the FIFO drops.
    always_ff @(posedge clk_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            min_q <= MIN_RESET[CW-1:0];
            max_q <= '0;
        end else if (clr_i) begin
            min_q <= MIN_RESET[CW-1:0];
            max_q <= '0;
        end else if (push) begin
            if (counter_i < min_q) begin
                min_q <= counter_i;
            end
            if (counter_i > max_q) begin
                max_q <= counter_i;
            end
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;

endmodule

// File: tb/tb_aia_latency_sampler.sv
// Scoreboard bench for the latency sampler with a behavioural cycle counter.
module tb_aia_latency_sampler;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CW     = 32;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          trig;
    logic          done;
    logic          clr;
    logic          cnt_rst;
    logic          cnt_start;
    logic          cnt_stop;
    logic [CW-1:0] cnt_model;
    logic [3:0]    level;
    logic          overflow;
    logic [CW-1:0] min_v;
    logic [CW-1:0] max_v;
    logic          busy;

    int            n_chk;
    int            n_err;
    logic [CW-1:0] sb[$];
    int            lat;

    aia_latency_sampler_if #(.CW(CW)) rd_if ();

    aia_latency_sampler #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE),
        .CW     (CW)
    ) dut (
        .clk_i       (clk),
        .rst_sys_ni  (rst_n),
        .enable_i    (enable),
        .trig_i      (trig),
        .done_i      (done),
        .clr_i       (clr),
        .cnt_rst_o   (cnt_rst),
        .cnt_start_o (cnt_start),
        .cnt_stop_o  (cnt_stop),
        .counter_i   (cnt_model),
        .rd          (rd_if),
        .level_o     (level),
        .overflow_o  (overflow),
        .min_o       (min_v),
        .max_o       (max_v),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: clear on cnt_rst, count while started and not stopped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_model <= '0;
        else if (cnt_rst) cnt_model <= '0;
        else if (cnt_start && !cnt_stop) cnt_model <= cnt_model + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted pop is compared against the oldest expected sample.
    always @(negedge clk) begin
        if (rst_n && rd_if.rd_valid_o && rd_if.rd_ready_i) begin
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else chk("rd_data", rd_if.rd_data_o, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One trig..done window of m RUN cycles; frozen count is m+1.
    task automatic measure(input int m, input bit exp_push, input bit pop_cap,
                           input bit clr_cap, output int k);
        trig = 1'b0; done = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        chk("cnt_rst_pulse", cnt_rst, 1);
        tick();
        chk("cnt_rst_end", cnt_rst, 0);
        chk("cnt_start_run", cnt_start, 1);
        trig = 1'b0;
        repeat (m) tick();
        done = 1'b1;
        if (exp_push) sb.push_back(CW'(m + 1));
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
            if (k == SETTLE + 1) begin
                rd_if.rd_ready_i = pop_cap;
                clr = clr_cap;
            end else begin
                rd_if.rd_ready_i = 1'b0;
                clr = 1'b0;
            end
        end
        chk("meas_idle", busy, 0);
        done = 1'b0;
    endtask

    task automatic drain();
        rd_if.rd_ready_i = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            tick();
            if (level == 0) break;
        end
        rd_if.rd_ready_i = 1'b0;
        chk("drain_level", level, 0);
        chk("sb_left", sb.size(), 0);
    endtask

    task automatic pulse_clr();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; enable = 1'b0; trig = 1'b0; done = 1'b0; clr = 1'b0;
        rd_if.rd_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_cnt_rst", cnt_rst, 0);
        chk("rst_cnt_start", cnt_start, 0);
        chk("rst_cnt_stop", cnt_stop, 0);
        chk("rst_valid", rd_if.rd_valid_o, 0);
        chk("rst_level", level, 0);
        chk("rst_data", rd_if.rd_data_o, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_min", min_v, 32'hFFFF_FFFF);
        chk("rst_max", max_v, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1; enable = 1'b1;
        tick();

        // 1: basic measurement, latency done->valid
        measure(9, 1'b1, 1'b0, 1'b0, lat);
        chk("t1_latency", lat, SETTLE + 2);
        chk("t1_valid", rd_if.rd_valid_o, 1);
        chk("t1_level", level, 1);
        chk("t1_min", min_v, 10);
        chk("t1_max", max_v, 10);
        drain();
        pulse_clr();

        // 2: three samples 7, 3, 12
        measure(6, 1'b1, 1'b0, 1'b0, lat);
        measure(2, 1'b1, 1'b0, 1'b0, lat);
        measure(11, 1'b1, 1'b0, 1'b0, lat);
        chk("t2_level", level, 3);
        chk("t2_min", min_v, 3);
        chk("t2_max", max_v, 12);
        drain();
        chk("t2_empty_valid", rd_if.rd_valid_o, 0);
        chk("t2_empty_hold", rd_if.rd_data_o, 12);
        pulse_clr();
        chk("t2_clr_min", min_v, 32'hFFFF_FFFF);
        chk("t2_clr_max", max_v, 0);

        // 3: overflow, then full with push and pop together
        for (int i = 0; i < 8; i++) measure(i + 2, 1'b1, 1'b0, 1'b0, lat);
        chk("t3_level8", level, 8);
        chk("t3_no_ovf", overflow, 0);
        measure(10, 1'b0, 1'b0, 1'b0, lat);
        chk("t3_level_full", level, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_max_dropped", max_v, 11);
        chk("t3_min", min_v, 3);
        tick();
        chk("t3_hold_a", rd_if.rd_data_o, sb[0]);
        tick();
        chk("t3_hold_b", rd_if.rd_data_o, sb[0]);
        measure(4, 1'b1, 1'b1, 1'b0, lat);
        chk("t3_pushpop_level", level, 8);
        chk("t3_pushpop_ovf", overflow, 1);
        drain();

        // 4: abort during RUN
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (3) tick();
        chk("t4_running", cnt_start, 1);
        enable = 1'b0;
        tick();
        chk("t4_start_off", cnt_start, 0);
        chk("t4_stop_off", cnt_stop, 0);
        chk("t4_busy", busy, 0);
        chk("t4_level", level, 0);
        enable = 1'b1;
        tick();
        done = 1'b1;
        repeat (2) tick();
        done = 1'b0;
        repeat (6) tick();
        chk("t4_late_done_level", level, 0);
        chk("t4_late_done_busy", busy, 0);

        // 5: ignored events
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("t5_done_idle", busy, 0);
        trig = 1'b1; done = 1'b1;
        tick();
        chk("t5_both_busy", busy, 1);
        chk("t5_both_rst", cnt_rst, 1);
        trig = 1'b0; done = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        chk("t5_no_restart", cnt_rst, 0);
        chk("t5_still_run", cnt_start, 1);
        chk("t5_no_stop", cnt_stop, 0);
        done = 1'b1;
        sb.push_back(3);
        lat = 0;
        while (busy && lat < 20) begin
            tick();
            lat++;
        end
        chk("t5_end_idle", busy, 0);
        done = 1'b0;
        chk("t5_one_sample", level, 1);
        drain();

        // 6: clr in CAPTURE with two queued, then async reset in STOP
        measure(4, 1'b1, 1'b0, 1'b0, lat);
        measure(6, 1'b1, 1'b0, 1'b0, lat);
        chk("t6_level2", level, 2);
        chk("t6_ovf_before", overflow, 1);
        measure(1, 1'b0, 1'b0, 1'b1, lat);
        chk("t6_clr_level", level, 0);
        chk("t6_clr_ovf", overflow, 0);
        chk("t6_clr_min", min_v, 32'hFFFF_FFFF);
        chk("t6_clr_max", max_v, 0);
        chk("t6_clr_valid", rd_if.rd_valid_o, 0);
        sb.delete();
        measure(3, 1'b1, 1'b0, 1'b0, lat);
        chk("t6_pre_rst_data", rd_if.rd_data_o, 4);
        tick();
        trig = 1'b1;
        repeat (2) tick();
        trig = 1'b0;
        tick();
        done = 1'b1;
        tick();
        chk("t6_in_stop", cnt_stop, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_arst_cnt_rst", cnt_rst, 0);
        chk("t6_arst_start", cnt_start, 0);
        chk("t6_arst_stop", cnt_stop, 0);
        chk("t6_arst_busy", busy, 0);
        chk("t6_arst_valid", rd_if.rd_valid_o, 0);
        chk("t6_arst_level", level, 0);
        chk("t6_arst_data", rd_if.rd_data_o, 0);
        chk("t6_arst_ovf", overflow, 0);
        chk("t6_arst_min", min_v, 32'hFFFF_FFFF);
        chk("t6_arst_max", max_v, 0);
        sb.delete();
        done = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/aia_latency_sampler.md
Name: aia_latency_sampler

Overview:
Controller and reader for the aplic_counter cycle counter, used to measure interrupt latency, for example from source assertion to claim.
- Drives the counter's start, stop and reset inputs from trigger and done events.
- Reads the frozen count after each measurement and pushes it into a sample FIFO.
- Tracks running min and max.
- Software-side logic drains the samples through a valid/ready read port.

Parameters:
DEPTH, 8, sample FIFO entries; power of 2, at least 2.
SETTLE, 2, cycles waited after stop before counter_i is sampled; at least 1.
CW, 32, counter and sample width.

Ports:
clk_i  in  1  clock
rst_sys_ni  in  1  reset, asynchronous, active-low
enable_i  in  1  sampler enable; low aborts any measurement
trig_i  in  1  measurement start event (level, rising edge used)
done_i  in  1  measurement end event (level, rising edge used)
clr_i  in  1  synchronous flush of FIFO, statistics and overflow
cnt_rst_o  out  1  to counter counter_rst_i
cnt_start_o  out  1  to counter start_i
cnt_stop_o  out  1  to counter stop_i
counter_i  in  CW  from counter counter_o
rd_valid_o  out  1  FIFO head valid
rd_ready_i  in  1  consumer accepts head
rd_data_o  out  CW  FIFO head sample
level_o  out  $clog2(DEPTH)+1  FIFO fill level
overflow_o  out  1  sticky: a sample was dropped
min_o  out  CW  smallest captured sample
max_o  out  CW  largest captured sample
busy_o  out  1  FSM not in IDLE

Behaviour:
Reset values:
- FSM in IDLE; all cnt_* outputs 0.
- FIFO empty: rd_valid_o=0, level_o=0, rd_data_o=0.
- overflow_o=0, min_o all ones, max_o=0, busy_o=0.

Edge detection:
- trig_i and done_i each pass through one internal flop for rising-edge detection.
- An edge is a registered level of 0 followed by a current level of 1.

FSM, one state per cycle unless noted:
- IDLE: on trig edge with enable_i=1, go to CLEAR.
- CLEAR: cnt_rst_o=1 for exactly 1 cycle, then go to RUN.
- RUN: cnt_start_o=1 throughout. On done edge, go to STOP.
- STOP: cnt_start_o=1 and cnt_stop_o=1. Hold for SETTLE cycles, then go to CAPTURE.
- CAPTURE: sample counter_i, push it to the FIFO, update min/max, drop cnt_start_o and cnt_stop_o, return to IDLE.
- Latency from done edge to rd_valid_o (FIFO previously empty) = SETTLE+2 cycles.

Event corner cases:
- trig edge outside IDLE is ignored; no re-arm and no restart.
- done edge outside RUN is ignored.
- trig and done edge in the same IDLE cycle: trig is taken, done is discarded.
- enable_i low in any state: next state IDLE, all cnt_* outputs 0 in that next cycle, no sample pushed.

clr_i:
- Next cycle: FIFO empty, overflow_o=0, min_o all ones, max_o=0.
- A push in the same cycle as clr_i is discarded. Statistics are not updated.
- The FSM is unaffected by clr_i.

FIFO:
- Circular buffer with CW-bit entries. Pointers are $clog2(DEPTH)+1 bits, wrap-around by MSB compare.
- Pop occurs when rd_valid_o && rd_ready_i.
- Full and push without pop: sample dropped, overflow_o set, min/max still updated.
- Full with push and pop in the same cycle: both accepted; level unchanged.
- Empty: rd_valid_o=0 and rd_data_o holds the last value. rd_ready_i is ignored.
- rd_data_o is stable while rd_valid_o=1 and rd_ready_i=0.

Statistics:
- min/max use unsigned compare and update in the CAPTURE cycle; values are visible the next cycle.
- A sample equal to the current value leaves it unchanged.

Counter contract:
- counter_i is frozen by the time CAPTURE is reached; SETTLE covers the counter's edge-detect pipeline.

Reset mid-operation:
- Asynchronous return to reset values. The counter is reset independently by its own rst_sys_ni.

Decomposition:
- Package aia_latency_pkg holds the FSM state enum (IDLE, CLEAR, RUN, STOP, CAPTURE) and the MIN_RESET constant (all ones, CW wide).
- One sub-module, aia_sample_fifo, parameterised by DEPTH and CW, with push/full, pop/valid, level, and synchronous flush.
- Edge detection reuses the existing aia_edge_detect.

Test Plan:
1. Basic measurement (SETTLE=2): trig edge, done 10 cycles after entering RUN, counter model counting. Expect cnt_rst_o pulse of 1 cycle, one FIFO entry equal to the frozen counter_i, rd_valid_o SETTLE+2 cycles after done, min_o=max_o=sample.
2. Three measurements with counts 7, 3, 12, drained with rd_ready_i=1. Expect rd_data_o sequence 7, 3, 12; min_o=3, max_o=12; level_o returns to 0.
3. Overflow (DEPTH=8): 9 measurements with no pops. Expect level_o=8, overflow_o=1 after the 9th, first pop returns the 1st sample. Then full with push and pop in the same cycle: level stays 8, overflow unchanged.
4. Abort: enable_i dropped during RUN. Expect next cycle cnt_start_o=0, busy_o=0, level_o unchanged. Extra done edge afterwards pushes nothing.
5. Ignored events: trig edge during RUN, done edge in IDLE, and simultaneous trig and done in IDLE. Expect exactly one measurement, ended only by the next done edge.
6. clr_i in the CAPTURE cycle with 2 entries queued. Expect level_o=0, overflow_o=0, min_o=FFFFFFFF, max_o=0. Async reset mid-STOP: all outputs at reset values immediately.
